// File: rtl/ex_13_mac_inverse.sv
// Recovers the MAC operand a = (g - OFFSET) / b, plus the remainder, using a
// 16-step restoring divider. One operation in flight, valid/ready on both sides.
module ex_13_mac_inverse #(
  parameter int unsigned     GW     = 16,
  parameter int unsigned     BW     = 8,
  parameter logic [GW-1:0]   OFFSET = 16'h004E
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [GW-1:0] g,
  input  logic [BW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] a,
  output logic [BW-1:0] rem,
  output logic          err_div0,
  output logic          err_under,
  output logic          err_ovf
);

  localparam int unsigned CW = $clog2(GW);

  typedef enum logic [1:0] {StIdle, StCheck, StDiv, StDone} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [BW-1:0] b_q, b_d;
  logic [GW-1:0] dvd_q, dvd_d;
  logic [BW:0]   r_q, r_d;
  logic [GW-1:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] a_q, a_d;
  logic [BW-1:0] rem_q, rem_d;
  logic          div0_q, div0_d;
  logic          under_q, under_d;
  logic          ovf_q, ovf_d;

  // One restoring-division step: shift in the next dividend bit, trial-subtract b.
  logic [BW:0]   r_shift;
  logic [BW:0]   r_sub;
  logic          q_bit;
  logic [BW:0]   r_next;
  logic [GW-1:0] q_next;

  always_comb begin
    r_shift = {r_q[BW-1:0], dvd_q[GW-1]};
    r_sub   = r_shift - {1'b0, b_q};
    q_bit   = (r_shift >= {1'b0, b_q});
    r_next  = q_bit ? r_sub : r_shift;
    q_next  = {q_q[GW-2:0], q_bit};
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    b_d     = b_q;
    dvd_d   = dvd_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    under_d = under_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          g_d     = g;
          b_d     = b;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (b_q == '0) begin
          a_d     = '1;
          rem_d   = '0;
          div0_d  = 1'b1;
          under_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = StDone;
        end else if (g_q < OFFSET) begin
          a_d     = '0;
          rem_d   = '0;
          div0_d  = 1'b0;
          under_d = 1'b1;
          ovf_d   = 1'b0;
          state_d = StDone;
        end else begin
          dvd_d   = g_q - OFFSET;
          r_d     = '0;
          q_d     = '0;
          cnt_d   = '0;
          state_d = StDiv;
        end
      end
      StDiv: begin
        dvd_d = {dvd_q[GW-2:0], 1'b0};
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(GW - 1)) begin
          a_d     = q_next[BW-1:0];
          rem_d   = r_next[BW-1:0];
          ovf_d   = |q_next[GW-1:BW];
          div0_d  = 1'b0;
          under_d = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      g_q     <= '0;
      b_q     <= '0;
      dvd_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
      under_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      b_q     <= b_d;
      dvd_q   <= dvd_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
      under_q <= under_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign a         = a_q;
  assign rem       = rem_q;
  assign err_div0  = div0_q;
  assign err_under = under_q;
  assign err_ovf   = ovf_q;

endmodule

// File: tb/tb_ex_13_mac_inverse.sv
// Randomised and directed checks of ex_13_mac_inverse against an arithmetic
// reference model of (g - OFFSET) / b with error classification.
module tb_ex_13_mac_inverse;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] g;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  a;
  logic [7:0]  rem;
  logic        err_div0;
  logic        err_under;
  logic        err_ovf;

  int n_cmp = 0;
  int n_err = 0;

  ex_13_mac_inverse dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g         (g),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
    .rem       (rem),
    .err_div0  (err_div0),
    .err_under (err_under),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  // {a, rem, err_div0, err_under, err_ovf}
  function automatic logic [18:0] model(input logic [15:0] gv, input logic [7:0] bv);
    int unsigned d, q, r;
    logic [7:0] qa, ra;
    if (bv == 8'd0) return {8'hFF, 8'h00, 3'b100};
    if (gv < 16'h004E) return {8'h00, 8'h00, 3'b010};
    d  = 32'(gv) - 32'h4E;
    q  = d / 32'(bv);
    r  = d % 32'(bv);
    qa = q[7:0];
    ra = r[7:0];
    return {qa, ra, 2'b00, (q > 255)};
  endfunction

  function automatic int model_lat(input logic [15:0] gv, input logic [7:0] bv);
    return (bv == 8'd0 || gv < 16'h004E) ? 1 : 17;
  endfunction

  function automatic logic [18:0] observed();
    return {a, rem, err_div0, err_under, err_ovf};
  endfunction

  // Accept one op, then count edges until out_valid; optionally pulse in_valid mid-DIV.
  task automatic drive_op(input logic [15:0] gv, input logic [7:0] bv, input bit pulse,
                          output int lat);
    int w = 0;
    out_ready = 1'b0;
    while (in_ready !== 1'b1 && w < 40) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1; g = gv; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0; g = 16'($urandom); b = 8'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (pulse && lat == 5) begin
        in_valid = 1'b1; g = 16'($urandom); b = 8'($urandom);
      end
      if (lat == 7) in_valid = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; g = 16'h03F6; b = 8'h34; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, in_ready, observed()} !== {2'b01, 19'd0}) begin
      n_err++;
      $display("FAIL reset_state: got ov=%b ir=%b res=%h, want ov=0 ir=1 res=0",
               out_valid, in_ready, observed());
    end
    in_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL reset_release_idle: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [15:0] gt [7];
    logic [7:0]  bt [7];
    int lat;
    gt = '{16'h03F6, 16'h03FB, 16'hFE4F, 16'h1234, 16'h0010, 16'h004E, 16'hFFFF};
    bt = '{8'h34,    8'h34,    8'hFF,    8'h00,    8'h03,    8'h07,    8'h01};
    for (int i = 0; i < 7; i++) begin
      drive_op(gt[i], bt[i], 1'b0, lat);
      n_cmp++;
      if (lat !== model_lat(gt[i], bt[i])) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, lat,
                 model_lat(gt[i], bt[i]));
      end
      n_cmp++;
      if (observed() !== model(gt[i], bt[i])) begin
        n_err++;
        $display("FAIL directed_result[%0d] g=%h b=%h: got %h, want %h", i, gt[i], bt[i],
                 observed(), model(gt[i], bt[i]));
      end
      release_result();
      n_cmp++;
      if ({out_valid, in_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL directed_release[%0d]: got ov=%b ir=%b, want ov=0 ir=1", i,
                 out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [18:0] held;
    drive_op(16'h03FB, 8'h34, 1'b0, lat);
    held = observed();
    n_cmp++;
    if (held !== model(16'h03FB, 8'h34)) begin
      n_err++;
      $display("FAIL bp_result: got %h, want %h", held, model(16'h03FB, 8'h34));
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2); g = 16'h0100; b = 8'h02;
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, in_ready, observed()} !== {2'b10, held}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b res=%h, want ov=1 ir=0 res=%h", i,
                 out_valid, in_ready, observed(), held);
      end
    end
    in_valid = 1'b0;
    release_result();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++;
      $display("FAIL bp_release: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_ignore_in_valid();
    int lat;
    drive_op(16'hABCD, 8'h9D, 1'b1, lat);
    n_cmp++;
    if ({lat[4:0], observed()} !== {5'd17, model(16'hABCD, 8'h9D)}) begin
      n_err++;
      $display("FAIL ignore_in_valid: got lat=%0d res=%h, want lat=17 res=%h", lat,
               observed(), model(16'hABCD, 8'h9D));
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    drive_op(16'h2000, 8'h21, 1'b0, lat);
    n_cmp++;
    if (observed() !== model(16'h2000, 8'h21)) begin
      n_err++;
      $display("FAIL b2b_first: got %h, want %h", observed(), model(16'h2000, 8'h21));
    end
    release_result();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_ready: got in_ready=%b, want 1", in_ready);
    end
    drive_op(16'h7777, 8'h13, 1'b0, lat);
    n_cmp++;
    if ({lat[4:0], observed()} !== {5'd17, model(16'h7777, 8'h13)}) begin
      n_err++;
      $display("FAIL b2b_second: got lat=%0d res=%h, want lat=17 res=%h", lat, observed(),
               model(16'h7777, 8'h13));
    end
    release_result();
  endtask

  task automatic test_reset_mid_div();
    int lat;
    bit seen;
    in_valid = 1'b1; g = 16'h5555; b = 8'h0B; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, in_ready, observed()} !== {2'b01, 19'd0}) begin
      n_err++;
      $display("FAIL mid_div_reset: got ov=%b ir=%b res=%h, want ov=0 ir=1 res=0",
               out_valid, in_ready, observed());
    end
    @(negedge clk); reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_div_discard: got stray_valid=%b ir=%b, want 0 and 1", seen, in_ready);
    end
    drive_op(16'h5555, 8'h0B, 1'b0, lat);
    n_cmp++;
    if ({lat[4:0], observed()} !== {5'd17, model(16'h5555, 8'h0B)}) begin
      n_err++;
      $display("FAIL mid_div_next_op: got lat=%0d res=%h, want lat=17 res=%h", lat,
               observed(), model(16'h5555, 8'h0B));
    end
    release_result();
  endtask

  task automatic test_random();
    int lat;
    logic [15:0] gv;
    logic [7:0]  bv;
    for (int i = 0; i < 60; i++) begin
      gv = 16'($urandom);
      bv = 8'($urandom);
      if ($urandom_range(0, 7) == 0) bv = 8'd0;
      if ($urandom_range(0, 7) == 0) gv = 16'($urandom_range(0, 16'h60));
      if ($urandom_range(0, 7) == 0) bv = 8'($urandom_range(1, 3));
      drive_op(gv, bv, 1'b0, lat);
      n_cmp++;
      if (lat !== model_lat(gv, bv) || observed() !== model(gv, bv)) begin
        n_err++;
        $display("FAIL random[%0d] g=%h b=%h: got lat=%0d res=%h, want lat=%0d res=%h", i,
                 gv, bv, lat, observed(), model_lat(gv, bv), model(gv, bv));
      end
      release_result();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_ignore_in_valid();
    test_back_to_back();
    test_reset_mid_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
